// File: rtl/shifter_pkg.sv
// Shared definitions for the register-specified shift sequencer: shift codes,
// controller states and the per-type shift-distance clamp.
package shifter_pkg;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam int LSL_LSR_MAX = 33;
    localparam int ASR_MAX     = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ_RS = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Clamped distances make every large-amount case a plain bit-serial shift:
    // one extra logical step past 32 clears the carry, ASR saturates at 32,
    // and ROR reduces modulo 32 with 0 meaning a full rotation.
    function automatic logic [5:0] clamp_rem(input logic [1:0] shift_type,
                                             input logic [7:0] amt);
        logic [5:0] rem;
        case (shift_type)
            SH_LSL, SH_LSR: rem = (amt > 8'(LSL_LSR_MAX)) ? 6'(LSL_LSR_MAX) : amt[5:0];
            SH_ASR:         rem = (amt > 8'(ASR_MAX)) ? 6'(ASR_MAX) : amt[5:0];
            default:        rem = (amt[4:0] == 5'd0) ? 6'd32 : {1'b0, amt[4:0]};
        endcase
        return rem;
    endfunction

endpackage

// File: rtl/rs_shift_step.sv
// One combinational shift step of 0..STEP_BITS positions; carry-out is the
// last bit shifted out, or the incoming carry when nothing moves.
module rs_shift_step
    import shifter_pkg::*;
#(
    parameter int STEP_BITS = 8,
    parameter int N_W       = $clog2(STEP_BITS + 1)
) (
    input  logic [31:0]    value,
    input  logic [1:0]     shift_type,
    input  logic [N_W-1:0] n,
    input  logic           carry,
    output logic [31:0]    result,
    output logic           carry_out
);

    logic [63:0] lsl_ext;
    logic [63:0] lsr_ext;
    logic [63:0] asr_ext;
    logic [63:0] rot_ext;

    always_comb begin
        // Widened operands keep the bit just past the result boundary for carry.
        lsl_ext = {32'd0, value} << n;
        lsr_ext = {value, 32'd0} >> n;
        asr_ext = $unsigned($signed({value, 32'd0}) >>> n);
        rot_ext = {value, value} >> n;

        result    = value;
        carry_out = carry;
        if (n != '0) begin
            case (shift_type)
                SH_LSL: begin
                    result    = lsl_ext[31:0];
                    carry_out = lsl_ext[32];
                end
                SH_LSR: begin
                    result    = lsr_ext[63:32];
                    carry_out = lsr_ext[31];
                end
                SH_ASR: begin
                    result    = asr_ext[63:32];
                    carry_out = asr_ext[31];
                end
                default: begin
                    result    = rot_ext[31:0];
                    carry_out = rot_ext[31];
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_rs_sequencer.sv
// Multi-cycle controller for shifts by a register amount: borrows a register-file
// read port for Rs, then shifts Rm up to STEP_BITS places per cycle.
module shift_rs_sequencer
    import shifter_pkg::*;
#(
    parameter int STEP_BITS = 8,
    parameter int DATA_W    = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic [1:0]        shift_type_i,
    input  logic [3:0]        rs_addr_i,
    input  logic [DATA_W-1:0] rm_data_i,
    input  logic              carry_in_i,
    output logic              rf_req_o,
    output logic [3:0]        rf_addr_o,
    input  logic              rf_gnt_i,
    input  logic [DATA_W-1:0] rf_data_i,
    output logic              stall_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o
);

    localparam int         N_W      = $clog2(STEP_BITS + 1);
    localparam logic [5:0] STEP_REM = 6'(STEP_BITS);

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] value_reg;
    logic              carry_reg;
    logic [1:0]        type_reg;
    logic [3:0]        rs_addr_reg;
    logic [5:0]        rem_reg;
    logic [DATA_W-1:0] result_reg;
    logic              carry_out_reg;

    logic              latch_en, load_rem, fin_zero, step_en, fin_step;
    logic [7:0]        amt;
    logic [5:0]        n_rem;
    logic [5:0]        rem_after;
    logic [DATA_W-1:0] step_value;
    logic              step_carry;
    logic              rf_data_unused;

    // Only the low byte of Rs is a shift amount.
    assign amt            = rf_data_i[7:0];
    assign rf_data_unused = ^rf_data_i[DATA_W-1:8];
    assign n_rem          = (rem_reg > STEP_REM) ? STEP_REM : rem_reg;
    assign rem_after      = rem_reg - n_rem;

    rs_shift_step #(.STEP_BITS(STEP_BITS)) u_step (
        .value      (value_reg),
        .shift_type (type_reg),
        .n          (n_rem[N_W-1:0]),
        .carry      (carry_reg),
        .result     (step_value),
        .carry_out  (step_carry)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_reg <= ST_IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        latch_en   = 1'b0;
        load_rem   = 1'b0;
        fin_zero   = 1'b0;
        step_en    = 1'b0;
        fin_step   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_i && !flush_i) begin
                    state_next = ST_REQ_RS;
                    latch_en   = 1'b1;
                end
            end
            ST_REQ_RS: begin
                if (flush_i) begin
                    state_next = ST_IDLE;
                end else if (rf_gnt_i) begin
                    if (amt == 8'd0) begin
                        state_next = ST_DONE;
                        fin_zero   = 1'b1;
                    end else begin
                        state_next = ST_SHIFT;
                        load_rem   = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (flush_i) begin
                    state_next = ST_IDLE;
                end else begin
                    step_en = 1'b1;
                    if (rem_after == 6'd0) begin
                        state_next = ST_DONE;
                        fin_step   = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        rf_req_o = (state_reg == ST_REQ_RS);
        busy_o   = (state_reg != ST_IDLE);
        done_o   = (state_reg == ST_DONE);
        stall_o  = ((state_reg == ST_IDLE) && start_i && !flush_i) ||
                   (state_reg == ST_REQ_RS) || (state_reg == ST_SHIFT);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            value_reg     <= '0;
            carry_reg     <= 1'b0;
            type_reg      <= SH_LSL;
            rs_addr_reg   <= '0;
            rem_reg       <= '0;
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
        end else begin
            if (latch_en) begin
                value_reg   <= rm_data_i;
                carry_reg   <= carry_in_i;
                type_reg    <= shift_type_i;
                rs_addr_reg <= rs_addr_i;
            end
            if (load_rem) rem_reg <= clamp_rem(type_reg, amt);
            if (step_en) begin
                value_reg <= step_value;
                carry_reg <= step_carry;
                rem_reg   <= rem_after;
            end
            // Result registers change only on entry to DONE and hold otherwise.
            if (fin_zero) begin
                result_reg    <= value_reg;
                carry_out_reg <= carry_reg;
            end
            if (fin_step) begin
                result_reg    <= step_value;
                carry_out_reg <= step_carry;
            end
        end
    end

    assign rf_addr_o = rs_addr_reg;
    assign result_o  = result_reg;
    assign carry_o   = carry_out_reg;

endmodule

// File: tb/tb_shift_rs_sequencer.sv
// Randomised bench for shift_rs_sequencer against an ARM-semantics shift model
// and a transaction-level timing model; directed cases pin literal results.
module tb_shift_rs_sequencer;
    import shifter_pkg::*;

    localparam int STEP = 8;

    logic        clk_i = 1'b0;
    logic        reset_i, start_i, flush_i, carry_in_i, rf_gnt_i;
    logic [1:0]  shift_type_i;
    logic [3:0]  rs_addr_i, rf_addr_o;
    logic [31:0] rm_data_i, rf_data_i, result_o;
    logic        rf_req_o, stall_o, busy_o, done_o, carry_o;

    always #5 clk_i = ~clk_i;

    shift_rs_sequencer #(.STEP_BITS(STEP), .DATA_W(32)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .flush_i(flush_i),
        .shift_type_i(shift_type_i), .rs_addr_i(rs_addr_i), .rm_data_i(rm_data_i),
        .carry_in_i(carry_in_i), .rf_req_o(rf_req_o), .rf_addr_o(rf_addr_o),
        .rf_gnt_i(rf_gnt_i), .rf_data_i(rf_data_i), .stall_o(stall_o),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .carry_o(carry_o)
    );

    int checks = 0;
    int errors = 0;
    int txn_id = 0;
    logic        chk_en = 1'b0;
    logic        exp_stall, exp_busy, exp_done, exp_req, chk_addr, exp_c;
    logic [3:0]  exp_addr;
    logic [31:0] exp_res;
    logic [31:0] prev_res = 32'd0;
    logic        prev_c = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s txn %0d t=%0t: got %h expected %h", name, txn_id, $time, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("stall", stall_o, exp_stall);
            chk("busy", busy_o, exp_busy);
            chk("done", done_o, exp_done);
            chk("rf_req", rf_req_o, exp_req);
            chk("result", result_o, exp_res);
            chk("carry", carry_o, exp_c);
            if (chk_addr) chk("rf_addr", rf_addr_o, exp_addr);
        end
    end

    // ARM operand-2 semantics computed directly from the shift amount.
    function automatic logic [32:0] ref_shift(input logic [1:0] t, input logic [31:0] rm,
                                              input logic [7:0] amt, input logic cin);
        int a;
        int r;
        a = amt;
        r = a % 32;
        if (a == 0) return {cin, rm};
        case (t)
            SH_LSL: if (a < 32) return {rm[32-a], rm << a};
                    else if (a == 32) return {rm[0], 32'd0};
                    else return 33'd0;
            SH_LSR: if (a < 32) return {rm[a-1], rm >> a};
                    else if (a == 32) return {rm[31], 32'd0};
                    else return 33'd0;
            SH_ASR: if (a < 32) return {rm[a-1], 32'($signed(rm) >>> a)};
                    else return {rm[31], {32{rm[31]}}};
            default: if (r == 0) return {rm[31], rm};
                     else return {rm[r-1], (rm >> r) | (rm << (32 - r))};
        endcase
    endfunction

    function automatic int shift_cycles(input logic [1:0] t, input logic [7:0] amt);
        int a;
        int rem;
        a = amt;
        if (a == 0) return 0;
        case (t)
            SH_LSL, SH_LSR: rem = (a > 33) ? 33 : a;
            SH_ASR:         rem = (a > 32) ? 32 : a;
            default:        rem = ((a % 32) == 0) ? 32 : (a % 32);
        endcase
        return (rem + STEP - 1) / STEP;
    endfunction

    task automatic set_idle();
        exp_stall = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_req = 1'b0;
        chk_addr = 1'b0; exp_res = prev_res; exp_c = prev_c;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Advance one cycle, or abort the transaction by flush or reset at cycle c.
    task automatic step_or_abort(input int c, input int flush_at, input int reset_at,
                                 output bit aborted);
        aborted = 1'b0;
        if (c == flush_at) begin
            flush_i = 1'b1;
            next_cycle();
            flush_i = 1'b0; rf_gnt_i = 1'b0;
            set_idle();
            next_cycle();
            aborted = 1'b1;
        end else if (c == reset_at) begin
            #2;
            reset_i = 1'b1;
            prev_res = 32'd0; prev_c = 1'b0;
            set_idle();
            chk_addr = 1'b1; exp_addr = 4'd0;
            #1;
            chk("reset_now_busy", busy_o, 1'b0);
            chk("reset_now_result", result_o, 32'd0);
            chk("reset_now_req", rf_req_o, 1'b0);
            next_cycle();
            reset_i = 1'b0; rf_gnt_i = 1'b0;
            set_idle();
            next_cycle();
            aborted = 1'b1;
        end else begin
            next_cycle();
        end
    endtask

    task automatic run_txn(input logic [1:0] t, input logic [31:0] rm, input logic [31:0] rs_val,
                           input logic cin, input logic [3:0] ra, input int gd,
                           input int flush_at, input int reset_at,
                           input bit lit, input logic [31:0] lit_res, input logic lit_c);
        logic [32:0] m;
        int nsh;
        int c;
        bit ab;
        txn_id++;
        m = lit ? {lit_c, lit_res} : ref_shift(t, rm, rs_val[7:0], cin);
        nsh = shift_cycles(t, rs_val[7:0]);
        $display("txn %0d type=%0d rm=%h rs=%h cin=%0d gd=%0d flush@%0d reset@%0d exp=%h/%0d",
                 txn_id, t, rm, rs_val, cin, gd, flush_at, reset_at, m[31:0], m[32]);
        start_i = 1'b1; flush_i = 1'b0; shift_type_i = t; rm_data_i = rm;
        carry_in_i = cin; rs_addr_i = ra; rf_gnt_i = 1'b0; rf_data_i = $urandom;
        set_idle();
        exp_stall = 1'b1;
        next_cycle();
        // Scramble the request inputs: the block must have latched them.
        start_i = 1'b0; rm_data_i = $urandom; shift_type_i = 2'($urandom);
        carry_in_i = 1'($urandom); rs_addr_i = 4'($urandom);
        c = 1;
        for (int i = 0; i <= gd; i++) begin
            rf_gnt_i = (i == gd);
            rf_data_i = rf_gnt_i ? rs_val : $urandom;
            exp_stall = 1'b1; exp_busy = 1'b1; exp_req = 1'b1; exp_done = 1'b0;
            chk_addr = 1'b1; exp_addr = ra;
            step_or_abort(c, flush_at, reset_at, ab);
            if (ab) return;
            c++;
        end
        for (int j = 0; j < nsh; j++) begin
            rf_gnt_i = 1'b0; rf_data_i = $urandom;
            exp_stall = 1'b1; exp_busy = 1'b1; exp_req = 1'b0; exp_done = 1'b0;
            chk_addr = 1'b0;
            step_or_abort(c, flush_at, reset_at, ab);
            if (ab) return;
            c++;
        end
        rf_gnt_i = 1'b0;
        prev_res = m[31:0]; prev_c = m[32];
        set_idle();
        exp_busy = 1'b1; exp_done = 1'b1;
        start_i = 1'($urandom);
        next_cycle();
        start_i = 1'b0;
        set_idle();
        next_cycle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] t;
        logic [7:0] amt;
        int gd, nsh, fa, ra_at;
        reset_i = 1'b1; start_i = 1'b0; flush_i = 1'b0; shift_type_i = 2'b00;
        rs_addr_i = 4'd0; rm_data_i = 32'd0; carry_in_i = 1'b0;
        rf_gnt_i = 1'b0; rf_data_i = 32'd0;
        set_idle();
        chk_addr = 1'b1; exp_addr = 4'd0;
        chk_en = 1'b1;
        next_cycle();
        next_cycle();
        reset_i = 1'b0;
        set_idle();
        next_cycle();

        run_txn(SH_LSL, 32'h8000_0001, 32'h0000_0001, 1'b0, 4'd3, 0, -1, -1, 1, 32'h0000_0002, 1'b1);
        run_txn(SH_LSR, 32'h8000_0000, 32'h0000_0020, 1'b0, 4'd5, 0, -1, -1, 1, 32'h0000_0000, 1'b1);
        run_txn(SH_LSR, 32'h8000_0000, 32'h0000_0028, 1'b1, 4'd6, 0, -1, -1, 1, 32'h0000_0000, 1'b0);
        run_txn(SH_ASR, 32'hF000_0000, 32'h0000_0100, 1'b1, 4'd7, 0, -1, -1, 1, 32'hF000_0000, 1'b1);
        run_txn(SH_ASR, 32'hF000_0000, 32'h0000_00C8, 1'b0, 4'd8, 0, -1, -1, 1, 32'hFFFF_FFFF, 1'b1);
        run_txn(SH_ROR, 32'h0000_00F1, 32'h0000_0004, 1'b1, 4'd9, 0, -1, -1, 1, 32'h1000_000F, 1'b0);
        run_txn(SH_ROR, 32'h0000_00F1, 32'h0000_0020, 1'b1, 4'd10, 0, -1, -1, 1, 32'h0000_00F1, 1'b0);
        run_txn(SH_ROR, 32'h0000_00F1, 32'h0000_0024, 1'b1, 4'd11, 0, -1, -1, 1, 32'h1000_000F, 1'b0);
        run_txn(SH_LSL, 32'h8000_0001, 32'h0000_0001, 1'b0, 4'd12, 3, -1, -1, 1, 32'h0000_0002, 1'b1);
        // Flush mid-shift: result must keep the previous DONE value.
        run_txn(SH_LSR, 32'hFFFF_0000, 32'h0000_0028, 1'b0, 4'd13, 0, 3, -1, 0, 32'd0, 1'b0);
        // start with flush in the same cycle: no request follows.
        txn_id++;
        $display("txn %0d start with flush", txn_id);
        start_i = 1'b1; flush_i = 1'b1;
        set_idle();
        next_cycle();
        start_i = 1'b0; flush_i = 1'b0;
        set_idle();
        next_cycle();
        run_txn(SH_ASR, 32'h8000_1234, 32'h0000_00C8, 1'b1, 4'd14, 1, -1, 4, 0, 32'd0, 1'b0);

        for (int k = 0; k < 200; k++) begin
            t = 2'($urandom);
            case ($urandom % 6)
                0: amt = 8'd0;
                1: amt = 8'($urandom_range(1, 31));
                2: amt = 8'd32;
                3: amt = 8'd33;
                4: amt = 8'($urandom);
                default: amt = 8'(32 * $urandom_range(1, 7));
            endcase
            gd = $urandom_range(0, 3);
            nsh = shift_cycles(t, amt);
            fa = (($urandom % 8) == 0) ? $urandom_range(1, gd + 1 + nsh) : -1;
            ra_at = (nsh > 0 && ($urandom % 20) == 0) ? gd + 2 + ($urandom % nsh) : -1;
            run_txn(t, $urandom, {24'($urandom), amt}, 1'($urandom), 4'($urandom),
                    gd, fa, ra_at, 0, 32'd0, 1'b0);
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_rs_sequencer.md
Name: shift_rs_sequencer

Overview:
Multi-cycle controller for register-specified shifts (Rm shifted by Rs[7:0]). The single-cycle immediate-shift operand path does not handle these. Decode/EX raises start_i for data-processing instructions with instr[27:25]=000, instr[7]=0, instr[4]=1. The block stalls the pipeline, borrows a register-file read port to fetch Rs, and shifts Rm iteratively. It then returns the operand-2 value and shifter carry to the ALU, following ARM semantics for shift amounts 0..255.

Parameters:
STEP_BITS, 8, maximum shift distance applied per SHIFT cycle; power of 2, range 1..32
DATA_W, 32, datapath width; fixed at 32 for ARM semantics

Ports:
clk_i  input  1  clock
reset_i  input  1  reset, asynchronous, active-high
start_i  input  1  register-shift request from EX, sampled in IDLE
flush_i  input  1  abort current operation (branch/exception)
shift_type_i  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
rs_addr_i  input  4  Rs register index
rm_data_i  input  32  Rm value
carry_in_i  input  1  current CPSR C flag
rf_req_o  output  1  request for the shared register-file read port
rf_addr_o  output  4  read address (Rs) while rf_req_o is high
rf_gnt_i  input  1  port granted; rf_data_i is valid in the same cycle
rf_data_i  input  32  Rs read data
stall_o  output  1  hold the IF/ID/EX pipeline registers
busy_o  output  1  state != IDLE
done_o  output  1  one-cycle pulse; result_o and carry_o are valid
result_o  output  32  shifted operand 2
carry_o  output  1  shifter carry-out

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; all registered outputs go to 0: result_o, carry_o, done_o, rf_req_o, rf_addr_o, busy_o. stall_o is 0 in IDLE with start_i low.
- States: IDLE, REQ_RS, SHIFT, DONE.
- IDLE, start_i=1 and flush_i=0:
  - latch rm, type, carry_in and rs_addr;
  - go to REQ_RS.
- stall_o is combinational: (IDLE & start_i & ~flush_i) | REQ_RS | SHIFT. It is 0 in DONE, so the pipeline advances in the DONE cycle.
- REQ_RS:
  - rf_req_o=1 and rf_addr_o=latched Rs; both held stable until grant.
  - On rf_gnt_i, capture amt=rf_data_i[7:0].
  - If amt==0, go to DONE with result=rm and carry=carry_in.
  - Otherwise load rem and go to SHIFT.
- rem clamp (makes every boundary case fall out of plain bit-serial semantics):
  - LSL/LSR: rem=min(amt,33). Amount 32 gives 0 with carry=last bit shifted out; amounts over 32 give 0 with carry 0.
  - ASR: rem=min(amt,32). Amounts of 32 or more give all sign bits with carry=rm[31].
  - ROR: rem=(amt[4:0]==0) ? 32 : amt[4:0]. Rotate by 32 leaves the value unchanged with carry=rm[31].
- SHIFT, each cycle:
  - n=min(rem,STEP_BITS);
  - value shifted or rotated by n;
  - carry = last bit shifted out (for n≥1);
  - rem-=n;
  - go to DONE when rem reaches 0.
  - Fill bits: LSL/LSR fill 0, ASR fills the sign bit, ROR rotates.
- DONE:
  - done_o=1 for exactly one cycle;
  - result_o and carry_o are registered and hold until the next DONE;
  - next state is IDLE; start_i is ignored in DONE.
- Latency: start at cycle 0, grant in cycle 1 ⇒ done_o in cycle 2+ceil(rem/STEP_BITS). With amt==0, done_o is in cycle 2. Each cycle of delayed grant adds one cycle.
- flush_i in any state: next state IDLE, no done_o, rf_req_o drops the next cycle. Flush has priority over start_i.
- reset_i mid-operation aborts immediately; no done_o.

Decomposition:
- shifter_pkg holds:
  - shift-type codes SH_LSL, SH_LSR, SH_ASR, SH_ROR;
  - the state enum;
  - clamp constants LSL_LSR_MAX=33 and ASR_MAX=32.
- One combinational sub-module, rs_shift_step: inputs value, type, n (0..STEP_BITS), carry; outputs shifted value and carry-out. The FSM, clamp logic and handshake live in shift_rs_sequencer.

Test Plan:
- LSL: rm=0x8000_0001, Rs=1, cin=0, immediate grant -> result 0x0000_0002, carry 1, done_o in cycle 3, stall_o high in cycles 0–2.
- LSR by 32 and by 40: rm=0x8000_0000 -> result 0, carry 1 (4 SHIFT cycles); by 40 -> result 0, carry 0 (5 SHIFT cycles).
- ASR with Rs=0x100 (amt byte 0): rm=0xF000_0000, cin=1 -> result 0xF000_0000, carry 1, done cycle 2. ASR by 200 -> 0xFFFF_FFFF, carry 1.
- ROR: rm=0x0000_00F1 by 4 -> 0x1000_000F, carry 0. By 32 -> 0x0000_00F1, carry 0. By 0x24 -> same as by 4.
- Grant held low 3 cycles: rf_req_o, rf_addr_o and stall_o stay stable; done_o delayed by exactly 3 cycles; result unchanged.
- flush_i asserted in SHIFT -> IDLE next cycle, no done_o, result_o keeps its previous value. start_i with flush_i in the same cycle -> no request. reset_i asserted mid-SHIFT -> all outputs 0 immediately.
